// File: rtl/ps2_scancode_rx.sv
`timescale 1ns/1ps
// ps2_scancode_rx: receives PS/2 keyboard frames and assembles Set-2 byte
// sequences (E0 / F0 prefixes) into a 16-bit scancode plus make/break flag.
//
// Handshake: scancode_valid is a one-cycle strobe with no ready; scancode and
// brk change only in the strobe cycle and hold until the next strobe.
// frame_err is a one-cycle strobe and never coincides with scancode_valid.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] scancode,
  output logic        brk,
  output logic        scancode_valid,
  output logic        frame_err,
  output logic [1:0]  rx_state_dbg,
  output logic [1:0]  asm_state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    ASM_BASE    = 2'd0,
    ASM_EXT     = 2'd1,
    ASM_BRK     = 2'd2,
    ASM_EXT_BRK = 2'd3
  } asm_state_t;

  // Synchronizers and falling-edge detector state
  logic clk_s1_q, clk_s_q, clk_prev_q;
  logic dat_s1_q, dat_s_q;
  logic fall;

  // Receiver state
  rx_state_t     rx_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [CW-1:0] to_cnt_q;
  logic          byte_done_q;
  logic          frame_err_q;

  // Assembler state
  asm_state_t    asm_q;
  logic [15:0]   scancode_q;
  logic          brk_q;
  logic          valid_q;

  // Two-flop synchronizers on both pins; idle-high reset value avoids a
  // spurious edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s_q    <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s_q    <= clk_s1_q;
      clk_prev_q <= clk_s_q;
      dat_s1_q   <= ps2_data;
      dat_s_q    <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s_q;

  // Frame receiver FSM with mid-frame inactivity timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q        <= RX_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_q == RX_IDLE) begin
        // Idle line never times out
        to_cnt_q <= '0;
        if (fall && !dat_s_q) begin
          rx_q     <= RX_DATA;
          bitcnt_q <= 3'd0;
        end
      end else if (fall) begin
        to_cnt_q <= '0;
        case (rx_q)
          RX_DATA: begin
            shift_q[bitcnt_q] <= dat_s_q;
            if (bitcnt_q == 3'd7) rx_q <= RX_PARITY;
            else                  bitcnt_q <= bitcnt_q + 3'd1;
          end
          RX_PARITY: begin
            par_q <= dat_s_q;
            rx_q  <= RX_STOP;
          end
          default: begin
            // Stop bit: accept only with stop=1 and odd overall parity
            rx_q <= RX_IDLE;
            if (dat_s_q && (^{shift_q, par_q})) byte_done_q <= 1'b1;
            else                                frame_err_q <= 1'b1;
          end
        endcase
      end else if (to_cnt_q == TO_LAST) begin
        // Clock stalled mid-frame: abandon the partial frame
        rx_q        <= RX_IDLE;
        to_cnt_q    <= '0;
        frame_err_q <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + CW'(1);
      end
    end
  end

  // Prefix assembler FSM: folds E0/F0 prefixes into one emitted scancode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= ASM_BASE;
      scancode_q <= 16'h0000;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (frame_err_q) begin
        // Any receive error drops a pending prefix
        asm_q <= ASM_BASE;
      end else if (byte_done_q) begin
        case (asm_q)
          ASM_BASE: begin
            if (shift_q == 8'hE0)      asm_q <= ASM_EXT;
            else if (shift_q == 8'hF0) asm_q <= ASM_BRK;
            else begin
              scancode_q <= {8'h00, shift_q};
              brk_q      <= 1'b0;
              valid_q    <= 1'b1;
            end
          end
          ASM_EXT: begin
            if (shift_q == 8'hF0)      asm_q <= ASM_EXT_BRK;
            else if (shift_q == 8'hE0) asm_q <= ASM_EXT;
            else begin
              scancode_q <= {8'hE0, shift_q};
              brk_q      <= 1'b0;
              valid_q    <= 1'b1;
              asm_q      <= ASM_BASE;
            end
          end
          ASM_BRK: begin
            if (shift_q == 8'hF0)      asm_q <= ASM_BRK;
            else if (shift_q == 8'hE0) asm_q <= ASM_EXT_BRK;
            else begin
              scancode_q <= {8'h00, shift_q};
              brk_q      <= 1'b1;
              valid_q    <= 1'b1;
              asm_q      <= ASM_BASE;
            end
          end
          default: begin
            if (shift_q != 8'hE0 && shift_q != 8'hF0) begin
              scancode_q <= {8'hE0, shift_q};
              brk_q      <= 1'b1;
              valid_q    <= 1'b1;
              asm_q      <= ASM_BASE;
            end
          end
        endcase
      end
    end
  end

  assign scancode       = scancode_q;
  assign brk            = brk_q;
  assign scancode_valid = valid_q;
  assign frame_err      = frame_err_q;
  assign rx_state_dbg   = rx_q;
  assign asm_state_dbg  = asm_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
`timescale 1ns/1ps
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and
// checks emitted scancodes, break flags, error strobes and latency.
module tb_ps2_scancode_rx;

  localparam int TO = 200;   // short timeout keeps the run brief
  localparam int HALF = 20;  // clk cycles per PS/2 clock half-period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] scancode;
  logic        brk;
  logic        scancode_valid;
  logic        frame_err;
  logic [1:0]  rx_state_dbg;
  logic [1:0]  asm_state_dbg;

  int total = 0;
  int bad = 0;

  // Event monitor bookkeeping
  int          cyc = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          overlap_cnt = 0;
  int          valid_cyc = 0;
  int          fall_cyc = 0;
  logic [15:0] last_code = 16'h0;
  logic        last_brk = 1'b0;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .scancode       (scancode),
    .brk            (brk),
    .scancode_valid (scancode_valid),
    .frame_err      (frame_err),
    .rx_state_dbg   (rx_state_dbg),
    .asm_state_dbg  (asm_state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes on the falling clock edge, away from the active edge
  always @(negedge clk) begin
    if (scancode_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      last_code <= scancode;
      last_brk  <= brk;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (scancode_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low pulse
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_inv, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ par_inv);
    send_bit(stop_b);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scancode", 32'(scancode), 32'h0);
    chk("rst_brk", 32'(brk), 32'h0);
    chk("rst_valid", 32'(scancode_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_rx_state", 32'(rx_state_dbg), 32'h0);
    chk("rst_asm_state", 32'(asm_state_dbg), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain make code; valid lands four rising edges after the stop-bit pin fall
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t1_count", 32'(valid_cnt), 32'd1);
    chk("t1_code", 32'(last_code), 32'h001C);
    chk("t1_brk", 32'(last_brk), 32'h0);
    chk("t1_latency", 32'(valid_cyc - fall_cyc), 32'd4);
    chk("t1_err", 32'(err_cnt), 32'd0);

    // Extended make, then extended break
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("t2_prefix_quiet", 32'(valid_cnt), 32'd1);
    send_frame(8'h6B, 1'b0, 1'b1);
    chk("t2_make_count", 32'(valid_cnt), 32'd2);
    chk("t2_make_code", 32'(last_code), 32'hE06B);
    chk("t2_make_brk", 32'(last_brk), 32'h0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("t2_prefixes_quiet", 32'(valid_cnt), 32'd2);
    send_frame(8'h6B, 1'b0, 1'b1);
    chk("t2_break_count", 32'(valid_cnt), 32'd3);
    chk("t2_break_code", 32'(last_code), 32'hE06B);
    chk("t2_break_brk", 32'(last_brk), 32'h1);

    // Parity error clears a pending E0 prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b1, 1'b1);
    chk("t3_err_count", 32'(err_cnt), 32'd1);
    chk("t3_no_valid", 32'(valid_cnt), 32'd3);
    chk("t3_asm_base", 32'(asm_state_dbg), 32'h0);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("t3_code", 32'(last_code), 32'h0075);
    chk("t3_brk", 32'(last_brk), 32'h0);

    // Bad stop bit
    send_frame(8'h72, 1'b0, 1'b0);
    chk("t4_err_count", 32'(err_cnt), 32'd2);
    chk("t4_no_valid", 32'(valid_cnt), 32'd4);
    chk("t4_rx_idle", 32'(rx_state_dbg), 32'h0);
    send_frame(8'h72, 1'b0, 1'b1);
    chk("t4_code", 32'(last_code), 32'h0072);
    chk("t4_count", 32'(valid_cnt), 32'd5);

    // E1 is an ordinary code
    send_frame(8'hE1, 1'b0, 1'b1);
    chk("e1_code", 32'(last_code), 32'h00E1);
    chk("e1_brk", 32'(last_brk), 32'h0);

    // Clock stalls after four data bits
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t5_rx_busy", 32'(rx_state_dbg), 32'h1);
    repeat (TO + 20) @(negedge clk);
    chk("t5_err_once", 32'(err_cnt), 32'd3);
    chk("t5_rx_idle", 32'(rx_state_dbg), 32'h0);
    ps2_data = 1'b1;
    repeat (3 * TO) @(negedge clk);
    chk("t5_idle_quiet", 32'(err_cnt), 32'd3);
    chk("t5_no_valid", 32'(valid_cnt), 32'd6);

    // Reset in the middle of a frame following F0
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("t6_prefix_brk", 32'(asm_state_dbg), 32'h2);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_scancode", 32'(scancode), 32'h0);
    chk("t6_rst_brk", 32'(brk), 32'h0);
    chk("t6_rst_asm", 32'(asm_state_dbg), 32'h0);
    chk("t6_rst_rx", 32'(rx_state_dbg), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h74, 1'b0, 1'b1);
    chk("t6_code", 32'(last_code), 32'h0074);
    chk("t6_brk", 32'(last_brk), 32'h0);
    chk("t6_count", 32'(valid_cnt), 32'd7);

    chk("no_overlap", 32'(overlap_cnt), 32'd0);
    chk("final_err_count", 32'(err_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
